norm_shift_ctrl: RTL
====================

Name: norm_shift_ctrl

Overview:
- FSM controller that drives the 16-bit shift register's control inputs (zero, init, ld, sh_en) and reads back its MSB.
- It normalises a loaded word: it shifts left until bit 15 is 1, then reports the shift count.
- It sits directly upstream of the shift register; the surrounding datapath supplies r_in to the register.
- A start/busy/done handshake connects it to the top-level sequencer.

Parameters:
- WIDTH, 16, data width of the shift register being controlled.
- CNT_W, 5, width of shift_cnt; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request: load r_in into the register and normalise it.
- abort  input  1  cancel an operation in progress.
- clr  input  1  request: clear the register (idle only).
- fill  input  1  request: preset the register to all ones (idle only).
- msb  input  1  bit WIDTH-1 of the shift register output.
- zero  output  1  to shift register: synchronous clear.
- init  output  1  to shift register: preset to all ones.
- ld  output  1  to shift register: parallel load.
- sh_en  output  1  to shift register: shift left by one.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- shift_cnt  output  CNT_W  number of shifts performed; holds until the next start.
- all_zero  output  1  set when the loaded word had no ones; holds until the next start.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - shift_cnt=0, all_zero=0.
  - zero, init, ld, sh_en, busy, done all 0.
- States: IDLE, LOAD, NORM, DONE. Encoding is free.
- IDLE:
  - Input priority: start > clr > fill.
  - start=1 → LOAD next edge; shift_cnt cleared to 0 and all_zero cleared to 0 on the same edge.
  - Otherwise clr=1 drives zero=1 combinationally in that cycle; fill=1 drives init=1 likewise. State stays IDLE.
- LOAD: ld=1 for exactly one cycle, then → NORM.
- NORM (msb is sampled each cycle; it reflects the register after the previous edge):
  - msb=1 → DONE. sh_en=0, shift_cnt unchanged.
  - msb=0 and shift_cnt<WIDTH-1 → sh_en=1, shift_cnt+1 at the edge, stay in NORM.
  - msb=0 and shift_cnt==WIDTH-1 → DONE. sh_en=0, all_zero←1, shift_cnt←WIDTH.
  - sh_en is the only Mealy output (a function of state and msb). All others decode from state only.
- DONE: done=1 for one cycle, then → IDLE. shift_cnt and all_zero persist until the next start.
- Control outputs:
  - zero, init, ld, sh_en are mutually exclusive in every cycle.
  - All four are 0 in DONE and in NORM except as stated above.
- Ignored inputs:
  - start, clr, fill are ignored while busy=1.
  - start while done=1 is ignored; it is accepted once the FSM is back in IDLE.
- abort:
  - In LOAD or NORM, abort=1 forces zero=1 that cycle, overriding ld and sh_en.
  - Next state is IDLE; done is not pulsed; shift_cnt keeps its partial value; all_zero=0.
  - abort in IDLE or DONE has no effect.
- Latency (start sampled in cycle 0):
  - ld in cycle 1; first NORM cycle is cycle 2.
  - done in cycle 3+k for k shifts (k ≤ WIDTH-1).
  - An all-zero word pulses done in cycle 2+WIDTH.
- Reset mid-operation: immediate return to IDLE with all outputs 0. The shift register has its own reset.
- The counter never wraps: maximum value is WIDTH, reached only on the all-zero exit.

Test Plan:
- Reset, then r_in=16'h8000 and start pulse → ld in cycle 1, no sh_en, done in cycle 3, shift_cnt=0, all_zero=0.
- r_in=16'h0001 and start → sh_en high for cycles 2–16 (15 shifts), done in cycle 18, shift_cnt=15, register=16'h8000.
- r_in=16'h0000 and start → 15 sh_en cycles, done in cycle 18, shift_cnt=16, all_zero=1, register=0.
- r_in=16'h00F0 and start; abort in cycle 4 → zero=1 in cycle 4, busy=0 from cycle 5, no done, register=0, shift_cnt=2.
- Idle with clr=1 and fill=1 together → zero=1, init=0. With fill alone → init=1, register=16'hFFFF. start+clr together → ld path taken, zero=0.
- r_in=16'h0100 and start; start re-pulsed in cycle 5 and rst pulsed low in cycle 7 → re-pulse ignored; after reset, state IDLE, shift_cnt=0, all controls 0, no done.

Source files
------------

// File: rtl/norm_shift_ctrl.sv
// norm_shift_ctrl
//
// Controller for a WIDTH-bit left-shift register. It loads a word into the
// register, then shifts left until the register MSB is set. It reports how
// many shifts were needed, and it flags a word that contained no ones.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   start      load r_in into the register and normalise it (idle only)
//   abort      cancel a load/normalise in progress (clears the register)
//   clr        clear the register (idle only, highest after start)
//   fill       preset the register to all ones (idle only)
//   msb        bit WIDTH-1 of the shift register
//   zero       register control: synchronous clear
//   init       register control: preset to all ones
//   ld         register control: parallel load
//   sh_en      register control: shift left by one
//   busy       high whenever the controller is not idle
//   done       one-cycle completion pulse
//   shift_cnt  shifts performed; holds until the next accepted start
//   all_zero   loaded word was zero; holds until the next accepted start
//
// CNT_W must satisfy 2**CNT_W > WIDTH so that the all-zero count (WIDTH) fits.

module norm_shift_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             clr,
    input  logic             fill,
    input  logic             msb,
    output logic             zero,
    output logic             init,
    output logic             ld,
    output logic             sh_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             all_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    // Last count at which a shift may still be issued, and the count that is
    // reported for an all-zero word.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             all_zero_reg, all_zero_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            all_zero_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            all_zero_reg <= all_zero_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        all_zero_next = all_zero_reg;
        zero          = 1'b0;
        init          = 1'b0;
        ld            = 1'b0;
        sh_en         = 1'b0;
        busy          = (state_reg != IDLE);
        done          = (state_reg == DONE);

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next    = LOAD;
                    cnt_next      = '0;
                    all_zero_next = 1'b0;
                end else if (clr) begin
                    zero = 1'b1;
                end else if (fill) begin
                    init = 1'b1;
                end
            end

            LOAD: begin
                if (abort) begin
                    // Clearing the register replaces the load.
                    zero          = 1'b1;
                    all_zero_next = 1'b0;
                    state_next    = IDLE;
                end else begin
                    ld         = 1'b1;
                    state_next = NORM;
                end
            end

            NORM: begin
                // msb shows the register after the previous edge, so a shift
                // issued this cycle is seen only in the next NORM cycle.
                if (abort) begin
                    zero          = 1'b1;
                    all_zero_next = 1'b0;
                    state_next    = IDLE;
                end else if (msb) begin
                    state_next = DONE;
                end else if (cnt_reg != CNT_LAST) begin
                    sh_en    = 1'b1;
                    cnt_next = cnt_reg + CNT_W'(1);
                end else begin
                    // WIDTH-1 shifts left the MSB clear: the word had no ones.
                    state_next    = DONE;
                    all_zero_next = 1'b1;
                    cnt_next      = CNT_FULL;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign shift_cnt = cnt_reg;
    assign all_zero  = all_zero_reg;

endmodule
